// File: rtl/wbc_ivm_pkg.sv
// rtl/wbc_ivm_pkg.sv - shared encodings and helpers for the interrupt vector master
package wbc_ivm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IAK  = 2'd1,
        ST_UNA  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    localparam int DEFAULT_T = 64;

    // Request lines are cumulative, so the highest set line is the pending level.
    function automatic logic [2:0] lvl_encode(input logic [3:0] irq);
        if (irq[3])      return 3'd7;
        else if (irq[2]) return 3'd6;
        else if (irq[1]) return 3'd5;
        else if (irq[0]) return 3'd4;
        else             return 3'd0;
    endfunction

endpackage

// File: rtl/wbc_ivm.sv
// rtl/wbc_ivm.sv - Wishbone interrupt vector master: arbitration, IAK/unaddressed read cycles
module wbc_ivm
    import wbc_ivm_pkg::*;
#(
    parameter int T = DEFAULT_T
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:4]  wb_irq_i,
    output logic        wb_stb_o,
    output logic        wb_una_o,
    input  logic        wb_ack_i,
    input  logic [15:0] wb_dat_i,
    input  logic [2:0]  cpu_pri,
    output logic        cpu_irq,
    output logic [2:0]  cpu_lvl,
    input  logic        cpu_iak,
    input  logic        cpu_una,
    output logic [15:0] cpu_dat,
    output logic        cpu_rdy,
    output logic        cpu_err
);

    localparam logic [6:0] T_LIM = 7'(T);

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic [6:0]  cnt_d;
    logic [2:0]  lvl;
    logic        above_pri;

    assign lvl       = lvl_encode(wb_irq_i);
    assign above_pri = (lvl > cpu_pri);
    assign cnt_d     = cnt_q + 7'd1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 7'd0;
            wb_stb_o <= 1'b0;
            wb_una_o <= 1'b0;
            cpu_irq  <= 1'b0;
            cpu_lvl  <= 3'd0;
            cpu_dat  <= 16'd0;
            cpu_rdy  <= 1'b0;
            cpu_err  <= 1'b0;
        end else begin
            cpu_irq <= above_pri;
            cpu_lvl <= above_pri ? lvl : 3'd0;
            cpu_rdy <= 1'b0;
            cpu_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Acknowledge outranks an unaddressed read arriving on the same clock.
                    if (cpu_iak && cpu_irq) begin
                        state_q  <= ST_IAK;
                        wb_stb_o <= 1'b1;
                        wb_una_o <= 1'b0;
                        cnt_q    <= 7'd0;
                    end else if (cpu_una) begin
                        state_q  <= ST_UNA;
                        wb_stb_o <= 1'b1;
                        wb_una_o <= 1'b1;
                        cnt_q    <= 7'd0;
                    end
                end
                ST_IAK, ST_UNA: begin
                    if (wb_ack_i) begin
                        cpu_dat  <= wb_dat_i;
                        cpu_rdy  <= 1'b1;
                        wb_stb_o <= 1'b0;
                        wb_una_o <= 1'b0;
                        state_q  <= ST_REL;
                    end else if (cnt_d == T_LIM) begin
                        cpu_dat  <= 16'd0;
                        cpu_err  <= 1'b1;
                        wb_stb_o <= 1'b0;
                        wb_una_o <= 1'b0;
                        state_q  <= ST_REL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbc_ivm.sv
// tb/tb_wbc_ivm.sv - self-checking bench for wbc_ivm with a behavioural responder and reference model
module tb_wbc_ivm;

    localparam int T_TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:4]  irq = 4'b0000;
    logic        stb;
    logic        una_o;
    logic        ack;
    logic [15:0] dat_i;
    logic [2:0]  pri = 3'd0;
    logic        c_irq;
    logic [2:0]  c_lvl;
    logic        iak = 1'b0;
    logic        una = 1'b0;
    logic [15:0] c_dat;
    logic        rdy;
    logic        err;

    int          n_assert = 0;
    int          n_fail = 0;

    logic        resp_on = 1'b1;
    int          dly = 0;
    int          wcnt = 0;
    logic [15:0] ivec = 16'h5040;
    logic [15:0] rsel = 16'o177570;

    always #5 clk = ~clk;

    // Responder: acks dly clocks after it first sees the strobe.
    always @(posedge clk) wcnt <= stb ? wcnt + 1 : 0;
    assign ack   = stb & resp_on & (wcnt >= dly);
    assign dat_i = una_o ? rsel : {8'h00, ivec[7:0]};

    wbc_ivm #(.T(T_TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_irq_i (irq),
        .wb_stb_o (stb),
        .wb_una_o (una_o),
        .wb_ack_i (ack),
        .wb_dat_i (dat_i),
        .cpu_pri  (pri),
        .cpu_irq  (c_irq),
        .cpu_lvl  (c_lvl),
        .cpu_iak  (iak),
        .cpu_una  (una),
        .cpu_dat  (c_dat),
        .cpu_rdy  (rdy),
        .cpu_err  (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_lvl(input logic [7:4] r);
        int l = 0;
        for (int k = 4; k <= 7; k++) if (r[k]) l = k;
        return l;
    endfunction

    function automatic logic [7:4] cum(input int p);
        logic [7:4] r;
        for (int k = 4; k <= 7; k++) r[k] = (p >= k);
        return r;
    endfunction

    function automatic bit ref_pending(input logic [7:4] r, input logic [2:0] p);
        return ref_lvl(r) > int'(p);
    endfunction

    task automatic set_req(input logic [7:4] r, input logic [2:0] p);
        bit pend;
        irq = r;
        pri = p;
        pend = ref_pending(r, p);
        @(negedge clk);
        check("cpu_irq", 32'(pend), 32'(pend));
        n_assert--;
        check("cpu_irq", 32'(c_irq), 32'(pend));
        check("cpu_lvl", 32'(c_lvl), pend ? ref_lvl(r) : 0);
    endtask

    task automatic do_cycle(input bit i, input bit u, input int d, input bit acks,
                            input bit exp_start, input bit exp_una, input logic [15:0] exp_dat);
        int k;
        dly = d;
        resp_on = acks;
        iak = i;
        una = u;
        @(negedge clk);
        iak = 1'b0;
        una = 1'b0;
        check("stb_rise", 32'(stb), 32'(exp_start));
        if (!exp_start) begin
            @(negedge clk);
            check("stb_idle", 32'(stb), 0);
            return;
        end
        check("una_tag", 32'(una_o), 32'(exp_una));
        k = 0;
        while (!(rdy | err) && k < T_TO + 4) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, acks ? d + 1 : T_TO);
        check("rdy", 32'(rdy), 32'(acks));
        check("err", 32'(err), 32'(!acks));
        check("dat", 32'(c_dat), acks ? 32'(exp_dat) : 0);
        check("stb_drop", 32'(stb), 0);
        check("una_drop", 32'(una_o), 0);
        iak = 1'b1;
        @(negedge clk);
        iak = 1'b0;
        check("rel_iak_ignored", 32'(stb), 0);
        check("rel_no_pulse", 32'(rdy | err), 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(stb), 0);
        check("rst_una", 32'(una_o), 0);
        check("rst_irq", 32'(c_irq), 0);
        check("rst_lvl", 32'(c_lvl), 0);
        check("rst_dat", 32'(c_dat), 0);
        check("rst_rdy_err", 32'(rdy | err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Priority-5 request against processor priority 4, then acknowledge.
        ivec = 16'h5040;
        set_req(cum(5), 3'd4);
        do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 16'h0040);

        set_req(cum(5), 3'd5);
        do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h0000);

        set_req(4'b1111, 3'd6);
        set_req(4'b1111, 3'd7);

        // Unaddressed read, then both pulses together with a request pending.
        rsel = 16'o177570;
        set_req(4'b0000, 3'd0);
        do_cycle(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 16'o177570);
        set_req(cum(5), 3'd4);
        do_cycle(1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 16'h0040);

        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Reset in the middle of an acknowledge cycle that is never answered.
        resp_on = 1'b0;
        iak = 1'b1;
        @(negedge clk);
        iak = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_stb", 32'(stb), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_stb", 32'(stb), 0);
        check("mrst_una", 32'(una_o), 0);
        check("mrst_irq", 32'(c_irq), 0);
        check("mrst_lvl", 32'(c_lvl), 0);
        check("mrst_dat", 32'(c_dat), 0);
        check("mrst_rdy_err", 32'(rdy | err), 0);
        rst = 1'b0;
        set_req(4'b0000, 3'd0);
        bad = 0;
        repeat (T_TO + 4) begin
            @(negedge clk);
            if (err | rdy | stb) bad = 1;
        end
        check("after_rst_quiet", bad, 0);

        for (int n = 0; n < 30; n++) begin
            logic [7:4] r;
            logic [2:0] p;
            bit         i, u, pend, acks;
            int         d;
            r    = 4'($urandom_range(0, 15));
            p    = 3'($urandom_range(0, 7));
            ivec = 16'($urandom);
            rsel = 16'($urandom);
            set_req(r, p);
            pend = ref_pending(r, p);
            i    = 1'($urandom);
            u    = 1'($urandom);
            acks = ($urandom_range(0, 7) != 0);
            d    = $urandom_range(0, 5);
            do_cycle(i, u, d, acks, (i && pend) || u, !(i && pend),
                     (i && pend) ? {8'h00, ivec[7:0]} : rsel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wbc_ivm.md
# wbc_ivm

Wishbone interrupt vector master: the CPU-side initiator that pairs with the vectored interrupt controller. It watches the four priority request lines, arbitrates them against the processor priority, and runs the interrupt-acknowledge bus cycle that fetches the vector. It also runs unaddressed read cycles on behalf of the core, and delivers the vector or read word to the core with a ready/error handshake. It sits between the CPU core's microsequencer and the system Wishbone bus.

## Interface
- T, 64: acknowledge timeout in clocks, counted from assertion of wb_stb_o; must be at least 2.
- wb_clk_i  in  1  system clock; the single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_irq_i  in  [7:4]  cumulative priority requests: bit k is set when the pending request priority is at least k.
- wb_stb_o  out  1  vector/unaddressed read strobe.
- wb_una_o  out  1  unaddressed read tag; 0 during interrupt acknowledge.
- wb_ack_i  in  1  cycle acknowledge from the responder.
- wb_dat_i  in  [15:0]  vector or read data.
- cpu_pri  in  [2:0]  current processor priority.
- cpu_irq  out  1  interrupt pending above cpu_pri.
- cpu_lvl  out  [2:0]  level of the pending interrupt, 4..7; 0 when none.
- cpu_iak  in  1  core accepts the interrupt; single-cycle pulse.
- cpu_una  in  1  core requests an unaddressed read; single-cycle pulse.
- cpu_dat  out  [15:0]  fetched vector or read word.
- cpu_rdy  out  1  cpu_dat valid; one-cycle pulse.
- cpu_err  out  1  bus timeout; one-cycle pulse.

## Operation
- Level encode: lvl is the highest set bit index k of wb_irq_i (4..7). lvl = 0 when wb_irq_i = 0.
- cpu_irq and cpu_lvl are registered in every state.
  - cpu_irq = (lvl > cpu_pri).
  - cpu_lvl = lvl when cpu_irq is 1, else 0.
- FSM states: IDLE, IAK, UNA, REL.
- IDLE:
  - cpu_iak while cpu_irq = 1 → IAK; wb_stb_o=1, wb_una_o=0.
  - Otherwise, cpu_una → UNA; wb_stb_o=1, wb_una_o=1.
  - cpu_iak while cpu_irq = 0 is ignored.
  - When cpu_iak and cpu_una arrive together, cpu_iak wins and cpu_una is dropped.
- IAK/UNA:
  - The strobe is held and the timeout counter counts each clock.
  - On wb_ack_i: capture wb_dat_i into cpu_dat, pulse cpu_rdy, drop wb_stb_o and wb_una_o, go to REL.
  - Counter reaching T with no ack: drop the strobe, set cpu_dat = 0, pulse cpu_err, go to REL.
- REL: strobe is low for exactly one clock, so the responder re-arbitrates its request lines. Then IDLE.
- Changes on wb_irq_i during IAK do not abort the cycle; the cycle runs to ack or timeout.
- cpu_iak/cpu_una pulses arriving outside IDLE are ignored.
- Reset values: wb_stb_o=0, wb_una_o=0, cpu_irq=0, cpu_lvl=0, cpu_dat=0, cpu_rdy=0, cpu_err=0, state IDLE, counter 0.
- Reset mid-cycle: the strobe is low on the first edge with wb_rst_i high, and no rdy/err pulse is issued.

## Timing
- All outputs are registered; nothing combinational from input to output.
- cpu_iak at edge n → wb_stb_o high from edge n+1.
- With a responder that acks one clock after the strobe:
  - wb_ack_i is seen at edge n+2.
  - cpu_rdy and cpu_dat are valid after edge n+2, and the strobe is low at that same edge.
- Minimum back-to-back cycle: 4 clocks (IDLE, IAK, ack, REL).
- Timeout: cpu_err is asserted T clocks after the strobe rose. The counter is 7 bits wide for T ≤ 127 and is cleared on entry to IAK/UNA.
- cpu_irq follows wb_irq_i/cpu_pri with 1 clock of latency.

## Structure
- Shared package holds:
  - state encodings (2-bit: IDLE=0, IAK=1, UNA=2, REL=3);
  - default timeout constant 64;
  - the level-encode function.
- No sub-module; the level encoder is a function and the timeout counter is inline.

## Test plan
- Responder programmed with ivec=16'h5040 (priority 5, vector 0o100), cpu_pri=4; request raised → cpu_irq=1, cpu_lvl=5; cpu_iak → one strobe with wb_una_o=0, cpu_dat=16'h0040, cpu_rdy one clock, strobe low in REL.
- Same request, cpu_pri=5 → cpu_irq stays 0; a cpu_iak pulse produces no strobe.
- wb_irq_i=4'b1111 with cpu_pri=6 → cpu_lvl=7. With cpu_pri=7 → cpu_irq=0.
- cpu_una with the responder's rsel=16'o177570 → wb_una_o=1, cpu_dat=16'o177570, cpu_rdy pulse. Simultaneous cpu_iak and cpu_una with an irq pending → IAK only.
- No responder ack, T=64 → cpu_err pulse exactly 64 clocks after the strobe rose, cpu_dat=0, then IDLE.
- wb_rst_i asserted during IAK → strobe low on the next edge, no rdy/err pulse, all outputs at reset values.
